control_unit: RTL and testbench

- Multicycle controller for the six-instruction processor.
- Holds the program counter and the instruction register, and decodes each 16-bit instruction.
- Sequences a Moore FSM that drives the register file's A/B read addresses, write address and write enable, plus the data-memory address/write, the register-file write-source mux and the ALU function select.
- Sits directly upstream of the 16x16 register file; its outputs connect straight to that file's address and write-enable inputs.

---
 rtl/control_unit.sv | 128 ++++++++++++
 tb/tb_control_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle controller for the six-instruction processor: PC, IR, decode and a
// Moore sequencer driving register-file, data-memory and ALU controls.
module control_unit #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned DADDR_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [15:0]        InstrData,
  output logic [PC_W-1:0]    PC,
  output logic [DADDR_W-1:0] D_addr,
  output logic               D_wr,
  output logic               RF_s,
  output logic [3:0]         RF_Waddr,
  output logic [3:0]         RF_Aaddr,
  output logic [3:0]         RF_Baddr,
  output logic               RF_W_en,
  output logic [2:0]         ALU_s0,
  output logic               Halted,
  output logic [3:0]         StateOut
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [3:0] OpNoop  = 4'd0;
  localparam logic [3:0] OpStore = 4'd1;
  localparam logic [3:0] OpLoad  = 4'd2;
  localparam logic [3:0] OpAdd   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpHalt  = 4'd5;

  state_e          r_state;
  state_e          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= StInit;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      // PC and IR only ever move on the FETCH exit edge, which also freezes them in HALT.
      if (r_state == StFetch) begin
        r_ir <= InstrData;
        r_pc <= r_pc + PC_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:   w_state_next = StFetch;
      StFetch:  w_state_next = StDecode;
      StDecode: begin
        unique case (r_ir[15:12])
          OpNoop:  w_state_next = StNoop;
          OpStore: w_state_next = StStore;
          OpLoad:  w_state_next = StLoadA;
          OpAdd:   w_state_next = StAdd;
          OpSub:   w_state_next = StSub;
          OpHalt:  w_state_next = StHalt;
          default: w_state_next = StNoop;
        endcase
      end
      StNoop, StStore, StAdd, StSub, StLoadB: w_state_next = StFetch;
      StLoadA:  w_state_next = StLoadB;
      StHalt:   w_state_next = StHalt;
      default:  w_state_next = StInit;
    endcase
  end

  always_comb begin
    D_addr   = '0;
    D_wr     = 1'b0;
    RF_s     = 1'b0;
    RF_Waddr = '0;
    RF_Aaddr = '0;
    RF_Baddr = '0;
    RF_W_en  = 1'b0;
    ALU_s0   = '0;
    Halted   = 1'b0;
    unique case (r_state)
      StLoadA, StLoadB: begin
        D_addr   = DADDR_W'(r_ir[11:4]);
        RF_s     = 1'b1;
        RF_Waddr = r_ir[3:0];
        RF_W_en  = (r_state == StLoadB);
      end
      StStore: begin
        D_addr   = DADDR_W'(r_ir[11:4]);
        RF_Aaddr = r_ir[3:0];
        D_wr     = 1'b1;
      end
      StAdd, StSub: begin
        RF_Aaddr = r_ir[11:8];
        RF_Baddr = r_ir[7:4];
        RF_Waddr = r_ir[3:0];
        ALU_s0   = (r_state == StAdd) ? 3'd1 : 3'd2;
        RF_W_en  = 1'b1;
      end
      StHalt:  Halted = 1'b1;
      default: ;
    endcase
    // Block any write from committing on the reset edge.
    if (Reset) begin
      RF_W_en = 1'b0;
      D_wr    = 1'b0;
    end
  end

  assign PC       = r_pc;
  assign StateOut = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit; outputs are compared at the
// negative edge after the cycle's inputs have been applied.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] InstrData;
  logic [6:0]  PC;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_s;
  logic [3:0]  RF_Waddr;
  logic [3:0]  RF_Aaddr;
  logic [3:0]  RF_Baddr;
  logic        RF_W_en;
  logic [2:0]  ALU_s0;
  logic        Halted;
  logic [3:0]  StateOut;

  int checks   = 0;
  int failures = 0;

  control_unit #(.PC_W(7), .DADDR_W(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InstrData(InstrData),
    .PC       (PC),
    .D_addr   (D_addr),
    .D_wr     (D_wr),
    .RF_s     (RF_s),
    .RF_Waddr (RF_Waddr),
    .RF_Aaddr (RF_Aaddr),
    .RF_Baddr (RF_Baddr),
    .RF_W_en  (RF_W_en),
    .ALU_s0   (ALU_s0),
    .Halted   (Halted),
    .StateOut (StateOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic [37:0] exp;
    string       name;
  } vec_t;

  // Packed order: state, pc, daddr, dwr, rfs, waddr, aaddr, baddr, wen, alu, halted.
  function automatic logic [37:0] ev(input logic [3:0] st, input logic [6:0] pc,
                                     input logic [7:0] da, input logic dwr, input logic rfs,
                                     input logic [3:0] wa, input logic [3:0] aa,
                                     input logic [3:0] ba, input logic wen,
                                     input logic [2:0] alu, input logic hlt);
    return {st, pc, da, dwr, rfs, wa, aa, ba, wen, alu, hlt};
  endfunction

  // Apply inputs for one cycle, check the Moore outputs, then let the edge occur.
  task automatic step(input logic rst, input logic [15:0] instr, input logic [37:0] exp,
                      input string name);
    logic [37:0] act;
    @(negedge Clock);
    Reset     = rst;
    InstrData = instr;
    #1;
    act = {StateOut, PC, D_addr, D_wr, RF_s, RF_Waddr, RF_Aaddr, RF_Baddr, RF_W_en,
           ALU_s0, Halted};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
    @(posedge Clock);
  endtask

  vec_t vecs[20];

  initial begin
    logic [6:0] p;
    vecs[0]  = '{1'b0, 16'h0000, ev(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "init"};
    vecs[1]  = '{1'b0, 16'h3125, ev(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "add_fetch"};
    vecs[2]  = '{1'b0, 16'h0000, ev(2, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "add_decode"};
    vecs[3]  = '{1'b0, 16'h0000, ev(7, 1, 8'h00, 0, 0, 5, 1, 2, 1, 1, 0), "add_exec"};
    vecs[4]  = '{1'b0, 16'h21B3, ev(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "load_fetch"};
    vecs[5]  = '{1'b0, 16'h0000, ev(2, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "load_decode"};
    vecs[6]  = '{1'b0, 16'h0000, ev(4, 2, 8'h1B, 0, 1, 3, 0, 0, 0, 0, 0), "load_a"};
    vecs[7]  = '{1'b0, 16'h0000, ev(5, 2, 8'h1B, 0, 1, 3, 0, 0, 1, 0, 0), "load_b"};
    vecs[8]  = '{1'b0, 16'h1404, ev(1, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "store_fetch"};
    vecs[9]  = '{1'b0, 16'h0000, ev(2, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "store_decode"};
    vecs[10] = '{1'b0, 16'h0000, ev(6, 3, 8'h40, 1, 0, 0, 4, 0, 0, 0, 0), "store_exec"};
    vecs[11] = '{1'b0, 16'h4789, ev(1, 3, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "sub_fetch"};
    vecs[12] = '{1'b0, 16'h0000, ev(2, 4, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "sub_decode"};
    vecs[13] = '{1'b0, 16'h0000, ev(8, 4, 8'h00, 0, 0, 9, 7, 8, 1, 2, 0), "sub_exec"};
    vecs[14] = '{1'b0, 16'hA123, ev(1, 4, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "ill_fetch"};
    vecs[15] = '{1'b0, 16'h0000, ev(2, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "ill_decode"};
    vecs[16] = '{1'b0, 16'h0000, ev(3, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "ill_noop"};
    vecs[17] = '{1'b0, 16'h5000, ev(1, 5, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "halt_fetch"};
    vecs[18] = '{1'b0, 16'h0000, ev(2, 6, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "halt_decode"};
    vecs[19] = '{1'b0, 16'h0000, ev(9, 6, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), "halt_enter"};

    // Two reset cycles from whatever power-up state the DUT holds.
    Reset     = 1'b1;
    InstrData = 16'(($urandom));
    @(posedge Clock);
    @(posedge Clock);

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].instr, vecs[i].exp, vecs[i].name);

    // HALT holds PC and IR even while a different word is on the ROM bus.
    for (int i = 0; i < 20; i++)
      step(1'b0, 16'h3125, ev(9, 6, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), "halt_hold");
    step(1'b1, 16'h0000, ev(9, 6, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1), "halt_reset");
    step(1'b0, 16'h0000, ev(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "halt_restart");

    // Reset during LOAD_A: no write enable, back to INIT.
    step(1'b0, 16'h21B3, ev(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rla_fetch");
    step(1'b0, 16'h0000, ev(2, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rla_decode");
    step(1'b1, 16'h0000, ev(4, 1, 8'h1B, 0, 1, 3, 0, 0, 0, 0, 0), "rla_load_a");
    step(1'b0, 16'h0000, ev(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rla_init");

    // Reset during LOAD_B: the write enable is masked while Reset is high.
    step(1'b0, 16'h21B3, ev(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rlb_fetch");
    step(1'b0, 16'h0000, ev(2, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rlb_decode");
    step(1'b0, 16'h0000, ev(4, 1, 8'h1B, 0, 1, 3, 0, 0, 0, 0, 0), "rlb_load_a");
    step(1'b1, 16'h0000, ev(5, 1, 8'h1B, 0, 1, 3, 0, 0, 0, 0, 0), "rlb_load_b");
    step(1'b0, 16'h0000, ev(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rlb_init");

    // Reset during STORE: the memory write is masked.
    step(1'b0, 16'h1404, ev(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rst_st_fetch");
    step(1'b0, 16'h0000, ev(2, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rst_st_decode");
    step(1'b1, 16'h0000, ev(6, 1, 8'h40, 0, 0, 0, 4, 0, 0, 0, 0), "rst_st_store");
    step(1'b0, 16'h0000, ev(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "rst_st_init");

    // 128 NOOPs: PC walks 0..127 and wraps to 0.
    p = 7'd0;
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 16'h0000, ev(1, p, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "nop_fetch");
      p = p + 7'd1;
      step(1'b0, 16'h0000, ev(2, p, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "nop_decode");
      step(1'b0, 16'h0000, ev(3, p, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "nop_exec");
    end
    step(1'b0, 16'h0000, ev(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0), "pc_wrapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
